// File: rtl/regfile_sb_pkg.sv
// Shared constants for the scoreboarded register file: default geometry
// and the hard-wired zero register address.
package regfile_sb_pkg;

  localparam int DW_DEF   = 32;
  localparam int AW_DEF   = 5;
  localparam int NRD_DEF  = 2;
  localparam int NWR_DEF  = 2;
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/regfile_sb_if.sv
// Bus bundle for the register file: read ports, issue port, writeback ports,
// flush and the pending-write count.
interface regfile_sb_if
  import regfile_sb_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int AW  = AW_DEF,
  parameter int NRD = NRD_DEF,
  parameter int NWR = NWR_DEF
) ();

  logic [NRD-1:0]    rd_en;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_valid;
  logic              iss_en;
  logic [AW-1:0]     iss_addr;
  logic              iss_ready;
  logic [NWR-1:0]    wb_en;
  logic [NWR*AW-1:0] wb_addr;
  logic [NWR*DW-1:0] wb_data;
  logic              flush;
  logic [AW:0]       busy_cnt;

  modport master (
    output rd_en, rd_addr, iss_en, iss_addr, wb_en, wb_addr, wb_data, flush,
    input  rd_data, rd_valid, iss_ready, busy_cnt
  );

  modport slave (
    input  rd_en, rd_addr, iss_en, iss_addr, wb_en, wb_addr, wb_data, flush,
    output rd_data, rd_valid, iss_ready, busy_cnt
  );

endinterface

// File: rtl/sb_popcnt.sv
// Combinational population count of a bit vector.
module sb_popcnt #(
  parameter int W  = 31,
  parameter int OW = 6
) (
  input  logic [W-1:0]  i_bits,
  output logic [OW-1:0] o_cnt
);

  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < W; i++) begin
      o_cnt = o_cnt + OW'(i_bits[i]);
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-ported register file with a pending-write scoreboard, same-cycle
// writeback bypass on reads and WAW-protected issue.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int AW  = AW_DEF,
  parameter int NRD = NRD_DEF,
  parameter int NWR = NWR_DEF
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);

  localparam int NREG = 2**AW;

  logic [DW-1:0]     r_mem [1:NREG-1];
  logic [NREG-1:1]   r_busy;
  logic [AW:0]       r_busy_cnt;

  logic [NREG-1:1]   w_busy_nxt;
  logic [AW:0]       w_busy_cnt_nxt;
  logic              w_iss_ready;
  logic              w_iss_take;
  logic [NRD*DW-1:0] w_rd_data;
  logic [NRD-1:0]    w_rd_valid;

  function automatic logic is_zero(input logic [AW-1:0] a);
    return a == AW'(REG_ZERO);
  endfunction

  function automatic logic busy_of(input logic [AW-1:0] a);
    return is_zero(a) ? 1'b0 : r_busy[a];
  endfunction

  // Returns {valid, data}; the highest-indexed matching writeback overrides storage.
  function automatic logic [DW:0] read_port(input logic [AW-1:0] a);
    logic [DW:0] res;
    logic        hit;
    res = {1'b1, {DW{1'b0}}};
    hit = 1'b0;
    if (!is_zero(a)) begin
      for (int w = 0; w < NWR; w++) begin
        if (bus.wb_en[w] && bus.wb_addr[w*AW +: AW] == a) begin
          res = {1'b1, bus.wb_data[w*DW +: DW]};
          hit = 1'b1;
        end
      end
      if (!hit) begin
        res = {!r_busy[a], r_mem[a]};
      end
    end
    return res;
  endfunction

  always_comb begin
    w_rd_data  = '0;
    w_rd_valid = '0;
    for (int p = 0; p < NRD; p++) begin
      if (bus.rd_en[p]) begin
        {w_rd_valid[p], w_rd_data[p*DW +: DW]} = read_port(bus.rd_addr[p*AW +: AW]);
      end
    end
  end

  assign w_iss_ready = !bus.flush && !rst && !busy_of(bus.iss_addr);
  assign w_iss_take  = bus.iss_en && w_iss_ready && !is_zero(bus.iss_addr);

  // Writeback clears first so a same-cycle issue to that address keeps the bit.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int w = 0; w < NWR; w++) begin
      if (bus.wb_en[w] && !is_zero(bus.wb_addr[w*AW +: AW])) begin
        w_busy_nxt[bus.wb_addr[w*AW +: AW]] = 1'b0;
      end
    end
    if (bus.flush) begin
      w_busy_nxt = '0;
    end else if (w_iss_take) begin
      w_busy_nxt[bus.iss_addr] = 1'b1;
    end
  end

  sb_popcnt #(
    .W  (NREG-1),
    .OW (AW+1)
  ) u_popcnt (
    .i_bits (w_busy_nxt),
    .o_cnt  (w_busy_cnt_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
      for (int i = 1; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_busy_cnt_nxt;
      for (int w = 0; w < NWR; w++) begin
        if (bus.wb_en[w] && !is_zero(bus.wb_addr[w*AW +: AW])) begin
          r_mem[bus.wb_addr[w*AW +: AW]] <= bus.wb_data[w*DW +: DW];
        end
      end
    end
  end

  assign bus.rd_data   = w_rd_data;
  assign bus.rd_valid  = w_rd_valid;
  assign bus.iss_ready = w_iss_ready;
  assign bus.busy_cnt  = r_busy_cnt;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios then random traffic, all checked
// against an array-based reference model of the register file and scoreboard.
module tb_regfile_sb;
  import regfile_sb_pkg::*;

  localparam int DW   = DW_DEF;
  localparam int AW   = AW_DEF;
  localparam int NRD  = NRD_DEF;
  localparam int NWR  = NWR_DEF;
  localparam int NREG = 2**AW;

  logic clk;
  logic rst;

  regfile_sb_if #(.DW(DW), .AW(AW), .NRD(NRD), .NWR(NWR)) bus ();

  regfile_sb #(.DW(DW), .AW(AW), .NRD(NRD), .NWR(NWR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] m_mem  [NREG];
  bit            m_busy [NREG];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_popcnt();
    int c = 0;
    for (int i = 1; i < NREG; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic logic m_ready();
    int a = int'(bus.iss_addr);
    if (bus.flush || rst) return 1'b0;
    return (a == 0) ? 1'b1 : !m_busy[a];
  endfunction

  task automatic m_read(input int p, output logic [DW-1:0] d, output logic v);
    int a = int'(bus.rd_addr[p*AW +: AW]);
    bit hit = 0;
    d = '0;
    v = 1'b0;
    if (!bus.rd_en[p]) return;
    for (int w = 0; w < NWR; w++) begin
      if (a != 0 && bus.wb_en[w] && int'(bus.wb_addr[w*AW +: AW]) == a) begin
        d   = bus.wb_data[w*DW +: DW];
        hit = 1;
      end
    end
    if (hit) v = 1'b1;
    else if (a == 0) v = 1'b1;
    else begin
      d = m_mem[a];
      v = !m_busy[a];
    end
  endtask

  task automatic check_all(input string tag);
    logic [DW-1:0] d;
    logic          v;
    #1;
    for (int p = 0; p < NRD; p++) begin
      m_read(p, d, v);
      chk($sformatf("%s.rd_data%0d", tag, p), 64'(bus.rd_data[p*DW +: DW]), 64'(d));
      chk($sformatf("%s.rd_valid%0d", tag, p), 64'(bus.rd_valid[p]), 64'(v));
    end
    chk($sformatf("%s.iss_ready", tag), 64'(bus.iss_ready), 64'(m_ready()));
    chk($sformatf("%s.busy_cnt", tag), 64'(bus.busy_cnt), 64'(m_popcnt()));
  endtask

  task automatic tick();
    logic [DW-1:0] nmem  [NREG];
    bit            nbusy [NREG];
    logic          rdy;
    int            a;
    nmem  = m_mem;
    nbusy = m_busy;
    rdy   = m_ready();
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        nmem[i]  = '0;
        nbusy[i] = 0;
      end
    end else begin
      for (int w = 0; w < NWR; w++) begin
        a = int'(bus.wb_addr[w*AW +: AW]);
        if (bus.wb_en[w] && a != 0) begin
          nmem[a]  = bus.wb_data[w*DW +: DW];
          nbusy[a] = 0;
        end
      end
      if (bus.flush) begin
        for (int i = 0; i < NREG; i++) nbusy[i] = 0;
      end else if (bus.iss_en && rdy && bus.iss_addr != 0) begin
        nbusy[int'(bus.iss_addr)] = 1;
      end
    end
    @(posedge clk);
    #1;
    m_mem  = nmem;
    m_busy = nbusy;
  endtask

  task automatic clr();
    bus.rd_en    = '0;
    bus.rd_addr  = '0;
    bus.iss_en   = 1'b0;
    bus.iss_addr = '0;
    bus.wb_en    = '0;
    bus.wb_addr  = '0;
    bus.wb_data  = '0;
    bus.flush    = 1'b0;
  endtask

  task automatic rd(input int p, input int a);
    bus.rd_en[p]              = 1'b1;
    bus.rd_addr[p*AW +: AW]   = AW'(a);
  endtask

  task automatic wb(input int w, input int a, input logic [DW-1:0] d);
    bus.wb_en[w]              = 1'b1;
    bus.wb_addr[w*AW +: AW]   = AW'(a);
    bus.wb_data[w*DW +: DW]   = d;
  endtask

  task automatic iss(input int a);
    bus.iss_en   = 1'b1;
    bus.iss_addr = AW'(a);
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 0;
    end
    clr();
    rst = 1'b1;
    #1;
    chk("rst_iss_ready", 64'(bus.iss_ready), 64'd0);
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    clr(); rd(0, 5); rd(1, 5);
    check_all("t035");
    chk("t035_data0", 64'(bus.rd_data[DW-1:0]), 64'd0);
    chk("t035_valid", 64'(bus.rd_valid), 64'd3);
    chk("t035_cnt", 64'(bus.busy_cnt), 64'd0);

    // Issue then writeback with bypass
    clr(); iss(3);
    check_all("t036_iss");
    chk("t036_rdy", 64'(bus.iss_ready), 64'd1);
    tick();
    clr(); rd(0, 3);
    check_all("t036_busy");
    chk("t036_valid0", 64'(bus.rd_valid[0]), 64'd0);
    chk("t036_cnt1", 64'(bus.busy_cnt), 64'd1);
    wb(0, 3, 32'hDEADBEEF);
    check_all("t036_byp");
    chk("t036_bypdata", 64'(bus.rd_data[DW-1:0]), 64'hDEADBEEF);
    chk("t036_bypvalid", 64'(bus.rd_valid[0]), 64'd1);
    tick();
    clr(); rd(0, 3);
    check_all("t036_after");
    chk("t036_cnt0", 64'(bus.busy_cnt), 64'd0);

    // Two writebacks to the same register
    clr(); wb(0, 7, 32'h11); wb(1, 7, 32'h22); rd(0, 7); rd(1, 7);
    check_all("t037_byp");
    chk("t037_bypdata", 64'(bus.rd_data[DW-1:0]), 64'h22);
    tick();
    clr(); rd(1, 7);
    check_all("t037_read");
    chk("t037_data", 64'(bus.rd_data[DW +: DW]), 64'h22);

    // WAW protection and issue+writeback to one address
    clr(); iss(4);
    check_all("t038_first");
    tick();
    clr(); iss(4);
    check_all("t038_again");
    chk("t038_blocked", 64'(bus.iss_ready), 64'd0);
    tick();
    clr(); iss(4); wb(0, 4, 32'h44);
    check_all("t038_wb_blocked");
    tick();
    clr(); iss(4); wb(1, 4, 32'h45); rd(0, 4);
    check_all("t038_iss_wb");
    chk("t038_rdy", 64'(bus.iss_ready), 64'd1);
    tick();
    clr(); rd(0, 4);
    check_all("t038_after");
    chk("t038_data", 64'(bus.rd_data[DW-1:0]), 64'h45);
    chk("t038_stillbusy", 64'(bus.rd_valid[0]), 64'd0);
    chk("t038_cnt", 64'(bus.busy_cnt), 64'd1);
    clr(); wb(0, 4, 32'h46);
    tick();

    // Flush
    clr(); iss(1); tick();
    clr(); iss(2); tick();
    clr(); iss(3); tick();
    clr();
    check_all("t039_pre");
    chk("t039_cnt3", 64'(bus.busy_cnt), 64'd3);
    bus.flush = 1'b1; wb(0, 9, 32'h55); iss(10);
    check_all("t039_flush");
    chk("t039_rdy", 64'(bus.iss_ready), 64'd0);
    tick();
    clr(); rd(0, 9); rd(1, 10);
    check_all("t039_post");
    chk("t039_cnt0", 64'(bus.busy_cnt), 64'd0);
    chk("t039_data", 64'(bus.rd_data[DW-1:0]), 64'h55);
    chk("t039_valid", 64'(bus.rd_valid), 64'd3);

    // Register zero, then reset mid-sequence
    clr(); wb(0, 0, 32'hFFFF); iss(0);
    check_all("t040_r0");
    tick();
    clr(); rd(0, 0);
    check_all("t040_r0read");
    chk("t040_r0data", 64'(bus.rd_data[DW-1:0]), 64'd0);
    chk("t040_r0valid", 64'(bus.rd_valid[0]), 64'd1);
    chk("t040_cnt", 64'(bus.busy_cnt), 64'd0);
    clr(); iss(6); wb(0, 12, 32'hABCD);
    tick();
    clr(); rst = 1'b1; iss(8); wb(1, 13, 32'h77); rd(0, 12); rd(1, 6);
    check_all("t040_inrst");
    chk("t040_rst_rdy", 64'(bus.iss_ready), 64'd0);
    tick();
    rst = 1'b0;
    clr(); rd(0, 12); rd(1, 13);
    check_all("t040_postrst");
    chk("t040_clr12", 64'(bus.rd_data[DW-1:0]), 64'd0);
    chk("t040_clr13", 64'(bus.rd_data[DW +: DW]), 64'd0);
    chk("t040_cnt0", 64'(bus.busy_cnt), 64'd0);

    // Random traffic, mostly on a few low registers to provoke collisions
    for (int n = 0; n < 400; n++) begin
      clr();
      rst       = ($urandom_range(0, 63) == 0);
      bus.flush = ($urandom_range(0, 15) == 0);
      for (int p = 0; p < NRD; p++) begin
        if ($urandom_range(0, 3) != 0)
          rd(p, ($urandom_range(0, 3) == 0) ? $urandom_range(0, NREG-1) : $urandom_range(0, 7));
      end
      for (int w = 0; w < NWR; w++) begin
        if ($urandom_range(0, 2) == 0)
          wb(w, $urandom_range(0, 7), $urandom());
      end
      if ($urandom_range(0, 1) == 0)
        iss(($urandom_range(0, 3) == 0) ? $urandom_range(0, NREG-1) : $urandom_range(0, 7));
      check_all($sformatf("rnd%0d", n));
      tick();
    end
    rst = 1'b0;
    clr();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
